// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   - Opcode encodings for the 1-bit ALU slice.
//   - FSM state enum for serial_alu_ctrl.
//   - carry_init(): initial carry-chain value for an opcode.
package serial_alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;  // a + b
  localparam logic [2:0] OP_SUBAB = 3'b001;  // a - b
  localparam logic [2:0] OP_SUBBA = 3'b010;  // b - a
  localparam logic [2:0] OP_OR    = 3'b011;  // a | b
  localparam logic [2:0] OP_AND   = 3'b100;  // a & b
  localparam logic [2:0] OP_ANDN  = 3'b101;  // ~a & b
  localparam logic [2:0] OP_XOR   = 3'b110;  // a ^ b
  localparam logic [2:0] OP_XNOR  = 3'b111;  // a ~^ b

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Subtractions are two's-complement adds of the inverted operand, so the
  // "+1" enters as the initial carry.
  function automatic logic carry_init(input logic [2:0] op);
    return (op == OP_SUBAB) || (op == OP_SUBBA);
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUBAB) || (op == OP_SUBBA);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice.
// Ports:
//   oper  [2:0] in  : opcode (see serial_alu_pkg)
//   a, b        in  : operand bits
//   c_in        in  : carry in
//   sum         out : result bit
//   c_out       out : carry out (0 for logic ops)
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic [2:0] oper,
  input  logic       a,
  input  logic       b,
  input  logic       c_in,
  output logic       sum,
  output logic       c_out
);

  logic x, y;

  always_comb begin
    x     = a;
    y     = b;
    sum   = 1'b0;
    c_out = 1'b0;
    case (oper)
      OP_ADD, OP_SUBAB, OP_SUBBA: begin
        if (oper == OP_SUBAB) y = ~b;
        if (oper == OP_SUBBA) x = ~a;
        sum   = x ^ y ^ c_in;
        c_out = (x & y) | (x & c_in) | (y & c_in);
      end
      OP_OR:   sum = a | b;
      OP_AND:  sum = a & b;
      OP_ANDN: sum = ~a & b;
      OP_XOR:  sum = a ^ b;
      OP_XNOR: sum = a ~^ b;
      default: sum = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer driving one alu_bit_slice over a W-bit operand pair,
// LSB first, one bit per clock, with a registered carry chain.
// Ports:
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   start            : request, accepted only when busy=0
//   oper [2:0]       : opcode, sampled with start
//   a, b [W-1:0]     : operands, sampled with start
//   busy             : operation in progress
//   done             : one-cycle pulse when result/c_out become valid
//   result [W-1:0]   : result, held until overwritten by the next run
//   c_out            : final carry (0 for logic ops)
//   ovf              : signed overflow, only with SERIAL_ALU_OVF_EN defined
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   oper,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     oper_q, oper_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   result_q, result_d;
  logic           c_out_q, c_out_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;

  logic slice_sum, slice_cout;

  alu_bit_slice u_slice (
    .oper  (oper_q),
    .a     (a_q[cnt_q]),
    .b     (b_q[cnt_q]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    oper_d   = oper_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          oper_d  = oper;
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          carry_d = carry_init(oper);
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift in from the MSB end so bit 0 lands at result[0] after W shifts.
        result_d = (result_q >> 1) | (W'(slice_sum) << (W - 1));
        carry_d  = slice_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          c_out_d = slice_cout;
          done_d  = 1'b1;
          // carry_q here is the carry into the MSB.
          ovf_d   = is_arith(oper_q) & (carry_q ^ slice_cout);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      oper_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      oper_q   <= oper_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
`ifdef SERIAL_ALU_OVF_EN
  assign ovf    = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl (W=8): directed cases plus random
// operations compared against an arithmetic reference model.
module tb_serial_alu_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   oper = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c_out;
  logic [W-1:0] result;
`ifdef SERIAL_ALU_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  serial_alu_ctrl #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .oper   (oper),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .c_out  (c_out)
`ifdef SERIAL_ALU_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } model_t;

  // Reference: whole-word arithmetic, signed overflow from operand/result signs.
  function automatic model_t model(input logic [2:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    model_t m;
    logic [W:0] wide;
    logic sx, sy, sr;
    m = '0;
    sx = x[W-1];
    sy = y[W-1];
    case (op)
      3'd0: wide = {1'b0, x} + {1'b0, y};
      3'd1: wide = {1'b0, x} + {1'b0, ~y} + 1;
      3'd2: wide = {1'b0, y} + {1'b0, ~x} + 1;
      3'd3: wide = {1'b0, x | y};
      3'd4: wide = {1'b0, x & y};
      3'd5: wide = {1'b0, ~x & y};
      3'd6: wide = {1'b0, x ^ y};
      default: wide = {1'b0, x ~^ y};
    endcase
    m.res = wide[W-1:0];
    m.c   = wide[W];
    sr    = m.res[W-1];
    case (op)
      3'd0: m.v = (sx == sy) && (sr != sx);
      3'd1: m.v = (sx != sy) && (sr != sx);
      3'd2: m.v = (sx != sy) && (sr != sy);
      default: m.v = 1'b0;
    endcase
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input model_t m);
    chk({tag, ".result"}, 32'(result), 32'(m.res));
    chk({tag, ".c_out"}, 32'(c_out), 32'(m.c));
`ifdef SERIAL_ALU_OVF_EN
    chk({tag, ".ovf"}, 32'(ovf), 32'(m.v));
`endif
  endtask

  // Launch one op and wait for done; optionally inject a start at run cycle 3.
  // Returns with the bench sitting in the done cycle (negedge).
  task automatic launch_and_wait(input string tag, input logic [2:0] op,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 input bit inject);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    oper = op; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      if (inject && cyc == 3) begin
        start = 1'b1; oper = ~op; a = ~x; b = x ^ y;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 32'(cyc), 32'(W + 1));
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(W));
    chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit inject);
    model_t m;
    m = model(op, x, y);
    launch_and_wait(tag, op, x, y, inject);
    check_result(tag, m);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    check_result({tag, ".hold"}, m);
  endtask

  initial begin
    model_t m1, m2;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;

    // Reset state
    #12;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.result", 32'(result), 32'd0);
    chk("reset.c_out", 32'(c_out), 32'd0);
    rst = 1'b0;

    // Directed cases
    run_op("add", 3'b000, 8'h5A, 8'h3C, 1'b0);
    run_op("subab", 3'b001, 8'h10, 8'h01, 1'b0);
    run_op("subba", 3'b010, 8'h10, 8'h01, 1'b0);
    run_op("xnor", 3'b111, 8'hF0, 8'hAA, 1'b0);
    run_op("andn", 3'b101, 8'hF0, 8'hAA, 1'b0);
    run_op("add_ovf", 3'b000, 8'h7F, 8'h01, 1'b0);
    run_op("sub_ovf", 3'b001, 8'h80, 8'h01, 1'b0);
    run_op("add_ff", 3'b000, 8'hFF, 8'hFF, 1'b0);
    run_op("sub_eq", 3'b001, 8'h33, 8'h33, 1'b0);

    // Start during busy is ignored
    run_op("ignore", 3'b000, 8'h21, 8'h42, 1'b1);

    // Start in the done cycle is accepted back-to-back
    m1 = model(3'b110, 8'hC3, 8'h5F);
    m2 = model(3'b010, 8'h07, 8'h30);
    launch_and_wait("b2b1", 3'b110, 8'hC3, 8'h5F, 1'b0);
    check_result("b2b1", m1);
    oper = 3'b010; a = 8'h07; b = 8'h30; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.busy_after", 32'(busy), 32'd1);
    chk("b2b.done_low", 32'(done), 32'd0);
    begin
      int cyc;
      cyc = 1;
      while (!done && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      chk("b2b2.latency", 32'(cyc), 32'(W + 1));
    end
    check_result("b2b2", m2);

    // Asynchronous reset mid-run
    @(negedge clk);
    oper = 3'b000; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.done", 32'(done), 32'd0);
    chk("rst_mid.result", 32'(result), 32'd0);
    chk("rst_mid.c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 3'b001, 8'h05, 8'h09, 1'b0);

    // Random operations
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      run_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial sequencer that drives the team's 1-bit ALU slice over a W-bit operand pair, LSB first, one bit per clock, with a registered carry chain between bits. It accepts an operation with a start/busy/done handshake, latches the operands, runs W slice evaluations, and presents a W-bit result plus the final carry. It sits between a register-file or test-harness front end and the single-bit datapath. It trades W cycles of latency for a one-slice footprint.

## Interface
- W, default 8: operand/result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- oper  input  3  opcode, sampled with start. Encodings: 000 a+b, 001 a-b, 010 b-a, 011 a|b, 100 a&b, 101 ~a&b, 110 a^b, 111 a~^b.
- a  input  W  operand A, sampled with start.
- b  input  W  operand B, sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result/c_out are valid from this cycle.
- result  output  W  result; holds until the next accepted start.
- c_out  output  1  final carry for arithmetic ops, 0 for logic ops; holds like result.
- ovf  output  1  signed overflow; present only with SERIAL_ALU_OVF_EN.

## Operation
- States: IDLE, RUN.
- IDLE with start=1:
  - latch oper, a, b;
  - clear bit counter to 0;
  - load carry register: 0 for 000, 1 for 001/010, 0 for logic ops;
  - go to RUN.
- RUN, each cycle:
  - slice inputs: oper, a[cnt], b[cnt], carry;
  - slice sum shifts into result from the MSB end (LSB-first fill), so the full result is aligned after W shifts;
  - slice carry-out is written to the carry register.
- Subtraction is a + ~b + 1 (001) or b + ~a + 1 (010). c_out=1 means no borrow.
- Logic ops: slice carry-out is 0, so c_out ends 0.
- On the edge that processes bit W-1: go to IDLE, update c_out from the final carry, and set done for one cycle.
- start while busy=1 is ignored; no queuing.
- start in the done cycle is accepted (state is already IDLE).
- The counter is ceil(log2(W)) bits, minimum 1. With W=1 the op finishes on the first RUN edge.
- Reset: state=IDLE, busy=0, done=0, result=0, c_out=0, ovf=0, counter=0, carry=0. Asserting rst mid-RUN aborts immediately; the partial result is discarded (result=0).

## Timing
- Start accepted at edge k.
- busy is high in the cycles after edges k .. k+W-1.
- Edge k+W: busy falls and done rises, both in the same cycle.
- done is high for exactly one cycle.
- Latency is W+1 clocks from the start-sampling edge to the first cycle with done=1.
- Back-to-back throughput: one operation per W+1 cycles.
- result changes only during RUN shifts or on reset; it is not cleared on start.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_ALU_OVF_EN defined:
  - ovf port and a one-bit register for the carry into the MSB are present;
  - for ops 000/001/010, ovf = carry-into-MSB XOR final carry, updated with c_out;
  - for logic ops, ovf=0.
- Not defined: no ovf port and no extra register.

## Structure
- Package serial_alu_pkg: oper encoding constants (OP_ADD, OP_SUBAB, OP_SUBBA, OP_OR, OP_AND, OP_ANDN, OP_XOR, OP_XNOR), state enum typedef (IDLE, RUN), and a carry-init function of oper.
- One sub-module: alu_bit_slice, the combinational 1-bit ALU (oper, a, b, c_in -> sum, c_out), instantiated once.

## Test plan
- W=8, oper 000, a=0x5A, b=0x3C: result=0x96, c_out=0; done exactly 9 cycles after the start edge; busy high for 8 cycles.
- oper 001, a=0x10, b=0x01: result=0x0F, c_out=1. oper 010 with the same operands: result=0xF1, c_out=0.
- oper 111, a=0xF0, b=0xAA: result=0xA5, c_out=0. oper 101 with the same operands: result=0x0A, c_out=0.
- start pulsed at cycle 3 of a running op with different operands: ignored, first result unchanged. A new start in the done cycle is accepted and busy stays high.
- rst asserted mid-RUN (cycle 4): busy, done, result, c_out go to 0 asynchronously. The next op after release completes correctly.
- With SERIAL_ALU_OVF_EN, oper 000, a=0x7F, b=0x01: result=0x80, c_out=0, ovf=1. oper 001, a=0x80, b=0x01: result=0x7F, ovf=1.
